// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Walks a 32-entry register file through its two combinational read ports
// and streams every register from the first index up to LAST_REG out over a
// valid/ready interface. Registers are fetched two at a time into a 2-slot
// snapshot buffer, so each word shows the contents the register had in its
// FETCH cycle.
//
// Parameters
//   LAST_REG        highest register index dumped (1..31)
//
// Configuration macro
//   DUMP_SKIP_ZERO_EN  when defined, the dump starts at register 1 and
//                      register 0 is never presented; otherwise it starts at 0.
//
// Ports
//   Clk            in   clock; all state changes on the rising edge
//   Rst            in   asynchronous active-high reset
//   Start          in   one-cycle dump request, only honoured in IDLE
//   ReadRegister1  out  register file read address, port 1 (ptr)
//   ReadRegister2  out  register file read address, port 2 (ptr+1)
//   ReadData1      in   register file read data, port 1
//   ReadData2      in   register file read data, port 2
//   DumpValid      out  DumpIndex/DumpData hold a word
//   DumpReady      in   consumer accepts the word at the rising edge
//   DumpIndex      out  register number of the current word
//   DumpData       out  register contents of the current word
//   Busy           out  high while fetching or draining
//   Done           out  one-cycle pulse after the last word transfers

module regfile_dump_reader #(
    parameter int LAST_REG = 31
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    output logic [4:0]  ReadRegister1,
    output logic [4:0]  ReadRegister2,
    input  logic [31:0] ReadData1,
    input  logic [31:0] ReadData2,
    output logic        DumpValid,
    input  logic        DumpReady,
    output logic [4:0]  DumpIndex,
    output logic [31:0] DumpData,
    output logic        Busy,
    output logic        Done
);

    localparam logic [5:0] LAST_IDX = 6'(LAST_REG);
`ifdef DUMP_SKIP_ZERO_EN
    localparam logic [5:0] FIRST_IDX = 6'd1;
`else
    localparam logic [5:0] FIRST_IDX = 6'd0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    // 6 bits wide so ptr+1 / ptr+2 past index 31 compare correctly.
    logic [5:0]  ptr_reg, ptr_next;
    logic        sel_reg, sel_next;          // buffer slot being presented
    logic [1:0]  slot_valid_reg, slot_valid_next;
    logic [5:0]  ptr_plus1;
    logic [5:0]  ptr_plus2;
    logic [31:0] rd_data [2];
    logic [31:0] cur_data;
    logic        cur_valid;

    assign ptr_plus1 = ptr_reg + 6'd1;
    assign ptr_plus2 = ptr_reg + 6'd2;
    assign rd_data[0] = ReadData1;
    assign rd_data[1] = ReadData2;

    // Snapshot buffer: both slots load together at the end of FETCH.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : slot_g
            logic [31:0] slot_data_reg;
            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst) begin
                    slot_data_reg <= 32'd0;
                end else if (state_reg == FETCH) begin
                    slot_data_reg <= rd_data[gi];
                end
            end
        end
    endgenerate

    assign cur_data  = sel_reg ? slot_g[1].slot_data_reg : slot_g[0].slot_data_reg;
    assign cur_valid = slot_valid_reg[sel_reg];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 6'd0;
            sel_reg        <= 1'b0;
            slot_valid_reg <= 2'b00;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            sel_reg        <= sel_next;
            slot_valid_reg <= slot_valid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        sel_next        = sel_reg;
        slot_valid_next = slot_valid_reg;
        ReadRegister1   = 5'd0;
        ReadRegister2   = 5'd0;
        DumpValid       = 1'b0;
        DumpIndex       = 5'd0;
        DumpData        = 32'd0;
        Busy            = 1'b0;
        Done            = 1'b0;

        case (state_reg)
            IDLE: begin
                if (Start) begin
                    ptr_next        = FIRST_IDX;
                    sel_next        = 1'b0;
                    slot_valid_next = 2'b00;
                    state_next      = FETCH;
                end
            end

            FETCH: begin
                Busy          = 1'b1;
                ReadRegister1 = ptr_reg[4:0];
                ReadRegister2 = ptr_plus1[4:0];
                slot_valid_next = {(ptr_plus1 <= LAST_IDX), 1'b1};
                sel_next        = 1'b0;
                state_next      = DRAIN;
            end

            DRAIN: begin
                Busy      = 1'b1;
                DumpValid = cur_valid;
                if (cur_valid) begin
                    DumpIndex = ptr_reg[4:0] + {4'd0, sel_reg};
                    DumpData  = cur_data;
                end
                // An empty slot1 still costs one cycle, which keeps every
                // fetch group at a fixed three cycles.
                if (!cur_valid || DumpReady) begin
                    slot_valid_next[sel_reg] = 1'b0;
                    if (!sel_reg) begin
                        sel_next = 1'b1;
                    end else begin
                        sel_next = 1'b0;
                        if (ptr_plus2 > LAST_IDX) begin
                            state_next = DONE;
                        end else begin
                            ptr_next   = ptr_plus2;
                            state_next = FETCH;
                        end
                    end
                end
            end

            DONE: begin
                Done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, ready, sel_dut;

    // DUT A: LAST_REG = 31, DUT B: LAST_REG = 4
    logic [4:0]  rr1_a, rr2_a, di_a, rr1_b, rr2_b, di_b;
    logic [31:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
    logic        dv_a, busy_a, done_a, dv_b, busy_b, done_b;
    logic        start_a, start_b;
    logic [31:0] rf_a [32];
    logic [31:0] rf_b [32];
    logic [31:0] exp_rf [32];

    assign rd1_a = rf_a[rr1_a];
    assign rd2_a = rf_a[rr2_a];
    assign rd1_b = rf_b[rr1_b];
    assign rd2_b = rf_b[rr2_b];
    assign start_a = start & ~sel_dut;
    assign start_b = start & sel_dut;

    regfile_dump_reader #(.LAST_REG(31)) dut_a (
        .Clk(clk), .Rst(rst), .Start(start_a),
        .ReadRegister1(rr1_a), .ReadRegister2(rr2_a),
        .ReadData1(rd1_a), .ReadData2(rd2_a),
        .DumpValid(dv_a), .DumpReady(ready),
        .DumpIndex(di_a), .DumpData(dd_a),
        .Busy(busy_a), .Done(done_a)
    );

    regfile_dump_reader #(.LAST_REG(4)) dut_b (
        .Clk(clk), .Rst(rst), .Start(start_b),
        .ReadRegister1(rr1_b), .ReadRegister2(rr2_b),
        .ReadData1(rd1_b), .ReadData2(rd2_b),
        .DumpValid(dv_b), .DumpReady(ready),
        .DumpIndex(di_b), .DumpData(dd_b),
        .Busy(busy_b), .Done(done_b)
    );

    logic [4:0]  rr1, rr2, di;
    logic [31:0] dd;
    logic        dv, busy, done;
    assign rr1  = sel_dut ? rr1_b  : rr1_a;
    assign rr2  = sel_dut ? rr2_b  : rr2_a;
    assign di   = sel_dut ? di_b   : di_a;
    assign dd   = sel_dut ? dd_b   : dd_a;
    assign dv   = sel_dut ? dv_b   : dv_a;
    assign busy = sel_dut ? busy_b : busy_a;
    assign done = sel_dut ? done_b : done_a;

`ifdef DUMP_SKIP_ZERO_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wr_rf(input int idx, input logic [31:0] val);
        if (sel_dut) rf_b[idx] = val;
        else         rf_a[idx] = val;
    endtask

    // mode 0: register k holds 32'h100+k, mode 1: random contents
    task automatic preload(input int mode);
        for (int k = 0; k < 32; k++) begin
            logic [31:0] v;
            v = (mode == 0) ? 32'h100 + 32'(k) : $urandom;
            exp_rf[k] = v;
            wr_rf(k, v);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, {31'd0, dv}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_index"}, {27'd0, di}, 32'd0);
        check({tag, "_data"},  dd, 32'd0);
        check({tag, "_rr1"},   {27'd0, rr1}, 32'd0);
        check({tag, "_rr2"},   {27'd0, rr2}, 32'd0);
    endtask

    function automatic logic ready_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one dump on the selected DUT. exp_cycles < 0 skips the latency
    // check; restart_at >= 0 pulses Start again in that cycle; abort_idx >= 0
    // asserts Rst when that index is presented.
    task automatic run_dump(input string tag, input int last, input int ready_mode,
                            input int exp_cycles, input int restart_at, input int abort_idx);
        int exp_q[$];
        int c, dones, done_c, words;
        logic prev_stall;
        logic [4:0] prev_idx;
        logic [31:0] prev_data;
        exp_q = {};
        for (int i = FIRST; i <= last; i++) exp_q.push_back(i);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;          // Start edge is cycle 0
        start = 1'b0;
        c = 0; dones = 0; done_c = -1; words = 0;
        prev_stall = 1'b0; prev_idx = '0; prev_data = '0;
        while (c < 2000 && (done_c < 0 || c < done_c + 4)) begin
            ready = ready_pat(ready_mode, c);
            start = (c == restart_at);
            @(negedge clk);
            if (abort_idx >= 0 && dv && int'(di) == abort_idx) begin
                rst = 1'b1;
                #1;
                check_quiet({tag, "_rst_now"});
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    check({tag, "_rst_no_done"}, {31'd0, done}, 32'd0);
                    check({tag, "_rst_no_busy"}, {31'd0, busy}, 32'd0);
                end
                @(posedge clk); #1;
                rst = 1'b0;
                start = 1'b0;
                return;
            end
            if (prev_stall) begin
                check({tag, "_stall_valid"}, {31'd0, dv}, 32'd1);
                check({tag, "_stall_index"}, {27'd0, di}, {27'd0, prev_idx});
                check({tag, "_stall_data"},  dd, prev_data);
            end
            prev_stall = 1'b0;
            if (dv) begin
                if (ready) begin
                    words++;
                    if (exp_q.size() == 0) begin
                        check({tag, "_extra_word"}, {27'd0, di}, 32'hFFFFFFFF);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        check({tag, "_index"}, {27'd0, di}, 32'(e));
                        check({tag, "_data"},  dd, exp_rf[e]);
                        // Overwrite registers already snapshotted; the
                        // dumped values must stay the FETCH-time ones.
                        wr_rf(e, ~exp_rf[e]);
                        if (((e - FIRST) % 2 == 0) && (e + 1 <= last))
                            wr_rf(e + 1, $urandom);
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_idx   = di;
                    prev_data  = dd;
                end
            end
            if (done) begin
                dones++;
                if (done_c < 0) begin
                    done_c = c;
                    if (exp_cycles >= 0) check({tag, "_done_cycle"}, 32'(c), 32'(exp_cycles));
                    check({tag, "_words_left"}, 32'(exp_q.size()), 32'd0);
                    check({tag, "_done_valid"}, {31'd0, dv}, 32'd0);
                    check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
                end
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        check({tag, "_done_count"}, 32'(dones), 32'd1);
        check({tag, "_word_count"}, 32'(words), 32'(last - FIRST + 1));
        // restore the model view for the next run
        for (int k = 0; k < 32; k++) wr_rf(k, exp_rf[k]);
    endtask

    function automatic int exp_cyc(input int last);
        int n;
        n = last - FIRST + 1;
        return ((n + 1) / 2) * 3;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; ready = 1'b0; sel_dut = 1'b0;
        for (int k = 0; k < 32; k++) begin
            rf_a[k] = '0; rf_b[k] = '0; exp_rf[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset_a");
        sel_dut = 1'b1; #1;
        check_quiet("reset_b");
        sel_dut = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // full dump, fixed pattern, ready high
        sel_dut = 1'b0; preload(0);
        run_dump("a_full", 31, 0, exp_cyc(31), -1, -1);
        sel_dut = 1'b1; preload(0);
        run_dump("b_full", 4, 0, exp_cyc(4), -1, -1);

        // ready toggling 1,0,0,1 with random contents
        sel_dut = 1'b0; preload(1);
        run_dump("a_toggle", 31, 1, -1, -1, -1);
        sel_dut = 1'b1; preload(1);
        run_dump("b_toggle", 4, 1, -1, -1, -1);

        // random ready plus a Start pulse while busy
        sel_dut = 1'b0; preload(1);
        run_dump("a_rand_restart", 31, 2, -1, 5, -1);

        // reset mid-dump, then a clean restart from the first index
        sel_dut = 1'b0; preload(1);
        run_dump("a_abort", 31, 0, -1, -1, 7);
        preload(1);
        run_dump("a_after_abort", 31, 0, exp_cyc(31), -1, -1);

        // ignored Start while busy on the short dump, latency unchanged
        sel_dut = 1'b1; preload(1);
        run_dump("b_restart", 4, 0, exp_cyc(4), 4, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
